// File: rtl/sa_tile_scheduler_pkg.sv
// sa_tile_scheduler_pkg: state encoding and parameter defaults shared by the tile scheduler files
package sa_tile_scheduler_pkg;
  localparam int M_DIM_DEF = 64;
  localparam int X_R_DEF = 16;
  localparam int W_C_DEF = 16;
  localparam int IDX_W_DEF = 8;
  typedef enum logic [6:0] {
    S_IDLE  = 7'b0000001,
    S_CLR   = 7'b0000010,
    S_LOAD  = 7'b0000100,
    S_FEED  = 7'b0001000,
    S_DRAIN = 7'b0010000,
    S_OUT   = 7'b0100000,
    S_DONE  = 7'b1000000
  } state_t;
  function automatic int drain_cyc_def(input int x_r, input int w_c);
    return x_r + w_c - 1;
  endfunction
endpackage

// File: rtl/sa_tile_scheduler_if.sv
// sa_tile_scheduler_if: control, feeder/array and result-handoff signals of the tile scheduler
interface sa_tile_scheduler_if import sa_tile_scheduler_pkg::*; #(parameter int IDX_W = IDX_W_DEF);
  logic I_START;
  logic [IDX_W-1:0] I_ROW_TILES;
  logic [IDX_W-1:0] I_COL_TILES;
  logic I_OPND_VLD;
  logic I_MGR_OVER;
  logic I_TILE_RDY;
  logic O_BUSY;
  logic O_DONE;
  logic O_SA_CLR;
  logic O_MGR_START;
  logic O_PE_SHIFT;
  logic [IDX_W-1:0] O_ROW_IDX;
  logic [IDX_W-1:0] O_COL_IDX;
  logic O_TILE_VLD;
  modport master (
    input I_START, I_ROW_TILES, I_COL_TILES, I_OPND_VLD, I_MGR_OVER, I_TILE_RDY,
    output O_BUSY, O_DONE, O_SA_CLR, O_MGR_START, O_PE_SHIFT, O_ROW_IDX, O_COL_IDX, O_TILE_VLD
  );
  modport slave (
    output I_START, I_ROW_TILES, I_COL_TILES, I_OPND_VLD, I_MGR_OVER, I_TILE_RDY,
    input O_BUSY, O_DONE, O_SA_CLR, O_MGR_START, O_PE_SHIFT, O_ROW_IDX, O_COL_IDX, O_TILE_VLD
  );
endinterface

// File: rtl/sa_tile_scheduler_idx_cnt.sv
// sa_tile_scheduler_idx_cnt: row-major 2-D tile index counter with latched tile counts and last flag
module sa_tile_scheduler_idx_cnt import sa_tile_scheduler_pkg::*; #(
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             I_CLK,
  input  logic             I_ASYN_RSTN,
  input  logic             I_SYNC_RSTN,
  input  logic             load,
  input  logic             adv,
  input  logic [IDX_W-1:0] row_tiles,
  input  logic [IDX_W-1:0] col_tiles,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic             last
);
  logic [IDX_W-1:0] row_n, col_n;
  logic col_end;
  assign col_end = col == col_n - IDX_W'(1);
  assign last = col_end && row == row_n - IDX_W'(1);
  // Advancing past the last tile returns both indices to 0 rather than overrunning the count
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN)
    if (!I_ASYN_RSTN) begin
      row_n <= IDX_W'(1);
      col_n <= IDX_W'(1);
      row <= '0;
      col <= '0;
    end else if (!I_SYNC_RSTN) begin
      row_n <= IDX_W'(1);
      col_n <= IDX_W'(1);
      row <= '0;
      col <= '0;
    end else if (load) begin
      row_n <= row_tiles == '0 ? IDX_W'(1) : row_tiles;
      col_n <= col_tiles == '0 ? IDX_W'(1) : col_tiles;
      row <= '0;
      col <= '0;
    end else if (adv) begin
      col <= col_end ? '0 : col + IDX_W'(1);
      row <= last ? '0 : col_end ? row + IDX_W'(1) : row;
    end
endmodule

// File: rtl/sa_tile_scheduler.sv
// sa_tile_scheduler: walks the output tile grid and sequences clear/feed/drain/handoff of the systolic array
module sa_tile_scheduler import sa_tile_scheduler_pkg::*; #(
  parameter int M_DIM     = M_DIM_DEF,
  parameter int X_R       = X_R_DEF,
  parameter int W_C       = W_C_DEF,
  parameter int DRAIN_CYC = drain_cyc_def(X_R, W_C),
  parameter int IDX_W     = IDX_W_DEF
) (
  input logic I_CLK,
  input logic I_ASYN_RSTN,
  input logic I_SYNC_RSTN,
  sa_tile_scheduler_if.master bus
);
  localparam int CNT_W = $clog2(DRAIN_CYC + 1);
  if (M_DIM < 1 || DRAIN_CYC < 1) begin : g_bad_param
    $error("sa_tile_scheduler: M_DIM and DRAIN_CYC must be >= 1");
  end
  state_t st, st_nxt;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] row, col;
  logic feed_shift, drain_end, last;
  assign feed_shift = st == S_FEED && bus.I_OPND_VLD;
  assign drain_end = st == S_DRAIN && cnt == CNT_W'(DRAIN_CYC - 1);
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN)
    if (!I_ASYN_RSTN) st <= S_IDLE;
    else st <= I_SYNC_RSTN ? st_nxt : S_IDLE;
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN)
    if (!I_ASYN_RSTN) cnt <= '0;
    else cnt <= I_SYNC_RSTN && st == S_DRAIN ? cnt + CNT_W'(1) : '0;
  always_comb begin
    st_nxt = st;
    case (st)
      S_IDLE:  st_nxt = bus.I_START ? S_CLR : S_IDLE;
      S_CLR:   st_nxt = S_LOAD;
      S_LOAD:  st_nxt = S_FEED;
      S_FEED:  st_nxt = feed_shift && bus.I_MGR_OVER ? S_DRAIN : S_FEED;
      S_DRAIN: st_nxt = drain_end ? S_OUT : S_DRAIN;
      S_OUT:   st_nxt = bus.I_TILE_RDY ? (last ? S_DONE : S_CLR) : S_OUT;
      S_DONE:  st_nxt = S_IDLE;
      default: st_nxt = S_IDLE;
    endcase
  end
  // Shift is the only output not purely decoded from state: feed stalls follow operand-valid
  always_comb begin
    bus.O_BUSY = st != S_IDLE;
    bus.O_DONE = st == S_DONE;
    bus.O_SA_CLR = st == S_CLR;
    bus.O_MGR_START = st == S_LOAD;
    bus.O_PE_SHIFT = feed_shift || st == S_DRAIN;
    bus.O_TILE_VLD = st == S_OUT;
    bus.O_ROW_IDX = row;
    bus.O_COL_IDX = col;
  end
  sa_tile_scheduler_idx_cnt #(.IDX_W(IDX_W)) u_idx (
    .I_CLK       (I_CLK),
    .I_ASYN_RSTN (I_ASYN_RSTN),
    .I_SYNC_RSTN (I_SYNC_RSTN),
    .load        (st == S_IDLE && bus.I_START),
    .adv         (st == S_OUT && bus.I_TILE_RDY),
    .row_tiles   (bus.I_ROW_TILES),
    .col_tiles   (bus.I_COL_TILES),
    .row         (row),
    .col         (col),
    .last        (last)
  );
endmodule
